// File: rtl/vz16_fetch.sv
// vz16 instruction fetch stage: one-outstanding-request memory fetcher feeding
// a small prefetch FIFO that presents {instr, instr_pc} to the core.
module vz16_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [15:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_data,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic [15:0]              instr,
  output logic                     instr_valid,
  output logic [15:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {FETCH, FULL} state_t;

  state_t          state_reg, state_next;
  logic            run_reg;
  logic [15:0]     fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]   level_reg, level_next;
  logic [31:0]     mem [DEPTH];
  logic            push, pop;

  // run_reg keeps imem_req low for the first cycle after reset release, so a
  // stale ack still in flight from before the reset can never be taken.
  assign imem_req    = run_reg && (state_reg == FETCH);
  assign imem_addr   = fetch_pc_reg;
  assign instr_valid = (level_reg != '0);
  assign level       = level_reg;

  assign push = imem_req && imem_ack && !redirect;
  assign pop  = instr_valid && !stall && !redirect;

  assign {instr, instr_pc} = instr_valid ? mem[rd_ptr_reg] : 32'h0;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;

    case (state_reg)
      FETCH: if (push && !pop && (level_reg == FULL_LVL - LW'(1))) state_next = FULL;
      FULL:  if (pop) state_next = FETCH;
      default: state_next = FETCH;
    endcase

    if (push) begin
      fetch_pc_next = fetch_pc_reg + 16'd1;
      wr_ptr_next   = wr_ptr_reg + AW'(1);
    end
    if (pop)
      rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase

    // Redirect overrides everything, discarding any same-cycle push or pop.
    if (redirect) begin
      state_next    = FETCH;
      fetch_pc_next = redirect_pc;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      level_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH;
      run_reg      <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      run_reg      <= 1'b1;
      fetch_pc_reg <= fetch_pc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {imem_data, fetch_pc_reg};
  end

endmodule

// File: tb/tb_vz16_fetch.sv
// Directed bench for vz16_fetch: cycle table for the main flow plus hand
// sequences for asynchronous reset and RESET_PC wrap-around.
module tb_vz16_fetch;

  logic        clk;
  logic        reset, reset_w;
  logic        imem_req, imem_req_w;
  logic [15:0] imem_addr, imem_addr_w;
  logic        imem_ack, imem_ack_w;
  logic [15:0] imem_data, imem_data_w;
  logic        stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr, instr_w, instr_pc, instr_pc_w;
  logic        instr_valid, instr_valid_w;
  logic [2:0]  level, level_w;

  int errors = 0;
  int checks = 0;

  // Memory model: the word at address a is a ^ 16'hA5A5.
  assign imem_data   = imem_addr ^ 16'hA5A5;
  assign imem_data_w = imem_addr_w ^ 16'hA5A5;

  vz16_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .level(level)
  );

  vz16_fetch #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset(reset_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_data(imem_data_w), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(16'h0000), .instr(instr_w),
    .instr_valid(instr_valid_w), .instr_pc(instr_pc_w), .level(level_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ack;
    logic        redir;
    logic [15:0] rpc;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_req;
    logic [15:0] e_addr;
    logic [2:0]  e_level;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic a, input logic r, input logic [15:0] rpc,
                     input logic v, input logic [15:0] ins, input logic [15:0] pc,
                     input logic rq, input logic [15:0] ad, input logic [2:0] lv);
    vec_t t;
    t.stall = s; t.ack = a; t.redir = r; t.rpc = rpc;
    t.e_valid = v; t.e_instr = ins; t.e_pc = pc;
    t.e_req = rq; t.e_addr = ad; t.e_level = lv;
    vecs.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc, input logic rq, input logic [15:0] ad,
                         input logic [2:0] lv);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".instr"}, 32'(instr), 32'(ins));
    chk({tag, ".pc"},    32'(instr_pc), 32'(pc));
    chk({tag, ".req"},   32'(imem_req), 32'(rq));
    chk({tag, ".addr"},  32'(imem_addr), 32'(ad));
    chk({tag, ".level"}, 32'(level), 32'(lv));
  endtask

  initial begin
    //   stall ack redir rpc       valid instr     pc        req addr      level
    add(0, 1, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h0000, 0); // req after reset
    add(0, 1, 0, 16'h0000,  1, 16'hA5A5, 16'h0000, 1, 16'h0001, 1); // first ack -> valid
    add(0, 1, 0, 16'h0000,  1, 16'hA5A4, 16'h0001, 1, 16'h0002, 1);
    add(0, 1, 0, 16'h0000,  1, 16'hA5A7, 16'h0002, 1, 16'h0003, 1);
    add(1, 1, 0, 16'h0000,  1, 16'hA5A7, 16'h0002, 1, 16'h0004, 2); // stall: fill
    add(1, 1, 0, 16'h0000,  1, 16'hA5A7, 16'h0002, 1, 16'h0005, 3);
    add(1, 1, 0, 16'h0000,  1, 16'hA5A7, 16'h0002, 0, 16'h0006, 4); // full
    add(1, 1, 0, 16'h0000,  1, 16'hA5A7, 16'h0002, 0, 16'h0006, 4);
    add(0, 1, 0, 16'h0000,  1, 16'hA5A6, 16'h0003, 1, 16'h0006, 3); // pop, req back
    add(0, 1, 0, 16'h0000,  1, 16'hA5A1, 16'h0004, 1, 16'h0007, 3); // push+pop
    add(0, 1, 0, 16'h0000,  1, 16'hA5A0, 16'h0005, 1, 16'h0008, 3);
    add(0, 0, 0, 16'h0000,  1, 16'hA5A3, 16'h0006, 1, 16'h0008, 2); // drain, slow mem
    add(0, 0, 0, 16'h0000,  1, 16'hA5A2, 16'h0007, 1, 16'h0008, 1);
    add(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h0008, 0);
    add(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h0008, 0);
    add(0, 1, 0, 16'h0000,  1, 16'hA5AD, 16'h0008, 1, 16'h0009, 1);
    add(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h0009, 0);
    add(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h0009, 0);
    add(0, 1, 0, 16'h0000,  1, 16'hA5AC, 16'h0009, 1, 16'h000A, 1);
    add(1, 1, 0, 16'h0000,  1, 16'hA5AC, 16'h0009, 1, 16'h000B, 2);
    add(1, 1, 0, 16'h0000,  1, 16'hA5AC, 16'h0009, 1, 16'h000C, 3);
    add(0, 1, 1, 16'h1234,  0, 16'h0000, 16'h0000, 1, 16'h1234, 0); // redirect + ack
    add(0, 0, 0, 16'h0000,  0, 16'h0000, 16'h0000, 1, 16'h1234, 0);
    add(0, 1, 0, 16'h0000,  1, 16'hB791, 16'h1234, 1, 16'h1235, 1);
    add(0, 1, 1, 16'h5000,  0, 16'h0000, 16'h0000, 1, 16'h5000, 0); // back-to-back
    add(0, 1, 1, 16'h6000,  0, 16'h0000, 16'h0000, 1, 16'h6000, 0);
    add(0, 1, 0, 16'h0000,  1, 16'hC5A5, 16'h6000, 1, 16'h6001, 1);

    reset = 1'b0; reset_w = 1'b0;
    imem_ack = 1'b1; imem_ack_w = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (3) tick();
    chk_all("reset", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    $display("reset: valid=%0d req=%0d level=%0d", instr_valid, imem_req, level);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; imem_ack = vecs[i].ack;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc,
              vecs[i].e_req, vecs[i].e_addr, vecs[i].e_level);
      $display("vec%0d: stall=%0d ack=%0d redir=%0d valid=%0d instr=%h pc=%h req=%0d addr=%h level=%0d",
               i, stall, imem_ack, redirect, instr_valid, instr, instr_pc, imem_req, imem_addr, level);
    end

    // Asynchronous reset with two entries buffered and a request pending.
    redirect = 1'b0; stall = 1'b1; imem_ack = 1'b1;
    tick();
    chk("areset.pre_level", 32'(level), 32'd2);
    imem_ack = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk_all("areset.now", 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    $display("async reset: valid=%0d req=%0d level=%0d", instr_valid, imem_req, level);
    imem_ack = 1'b1;
    tick();
    chk("areset.held_level", 32'(level), 32'd0);
    reset = 1'b1; stall = 1'b0;
    tick();
    chk_all("areset.rel1", 0, 16'h0000, 16'h0000, 1, 16'h0000, 0);
    tick();
    chk_all("areset.rel2", 1, 16'hA5A5, 16'h0000, 1, 16'h0001, 1);
    $display("restart: valid=%0d instr=%h pc=%h addr=%h", instr_valid, instr, instr_pc, imem_addr);

    // RESET_PC near the top of the address space wraps to zero.
    reset_w = 1'b1;
    tick();
    chk("wrap.valid0", 32'(instr_valid_w), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] epc;
      epc = 16'hFFFE + 16'(k);
      tick();
      chk($sformatf("wrap%0d.pc", k), 32'(instr_pc_w), 32'(epc));
      chk($sformatf("wrap%0d.instr", k), 32'(instr_w), 32'(epc ^ 16'hA5A5));
      $display("wrap%0d: valid=%0d pc=%h instr=%h", k, instr_valid_w, instr_pc_w, instr_w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
